// File: rtl/sccb_master_pkg.sv
// Shared SCCB command/response codes, FSM encoding and latched-command record.
package sccb_master_pkg;
  localparam logic [2:0] MCMD_IDLE  = 3'b000;
  localparam logic [2:0] MCMD_WR    = 3'b001;
  localparam logic [2:0] MCMD_RD    = 3'b010;
  localparam logic [1:0] SRESP_NULL = 2'b00;
  localparam logic [1:0] SRESP_DVA  = 2'b01;
  localparam logic [1:0] SRESP_ERR  = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE, ST_START, ST_BYTE, ST_XBIT, ST_STOP, ST_GAP, ST_RESP
  } state_t;

  typedef enum logic [1:0] {PH_ID = 2'd0, PH_ADDR = 2'd1, PH_DATA = 2'd2} phase_t;

  typedef struct packed {
    logic       rd;
    logic [6:0] id;
    logic [7:0] reg_addr;
    logic [7:0] wdata;
    logic [7:0] div;
  } cmd_t;
endpackage

// File: rtl/sccb_tick_gen.sv
// Quarter-bit prescaler: one tick every max(div,1)+1 clocks, restartable.
module sccb_tick_gen (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] div,
  input  logic       restart,
  output logic       tick
);
  logic [7:0] cnt, lim;

  assign lim  = (div == 8'd0) ? 8'd1 : div;
  assign tick = (cnt == lim);

  always_ff @(posedge clk or posedge rst)
    if (rst)                  cnt <= '0;
    else if (restart || tick) cnt <= '0;
    else                      cnt <= cnt + 8'd1;
endmodule

// File: rtl/sccb_master.sv
// SCCB (3-phase write / 2-phase write + 2-phase read) master with open-drain data.
module sccb_master
  import sccb_master_pkg::*;
(
  input  logic        config_clk,
  input  logic        config_reset,
  input  logic [7:0]  sccb_div,
  input  logic [2:0]  mcmd,
  input  logic [14:0] maddr,
  input  logic [7:0]  mdata,
  output logic        scmdaccept,
  output logic [1:0]  sresp,
  output logic [7:0]  sdata,
  output logic        sio_c,
  output logic        sio_d_o,
  output logic        sio_d_oe,
  input  logic        sio_d_i
);
  state_t     state, state_n;
  phase_t     phase, phase_n;
  logic [1:0] q, q_n;
  logic [2:0] bitcnt, bitcnt_n;
  logic [7:0] shreg, shreg_n, tx_byte;
  logic       rd2, rd2_n, c_n, oe_n, err, err_n, rdy, tick, rx, last;
  cmd_t       cmd;

  sccb_tick_gen u_tick (
    .clk(config_clk), .rst(config_reset), .div(cmd.div), .restart(scmdaccept), .tick(tick)
  );

  // rdy keeps the first post-reset cycle from accepting a command.
  assign scmdaccept = (state == ST_IDLE) && rdy && (mcmd != MCMD_IDLE);
  assign sresp      = (state == ST_RESP) ? (err ? SRESP_ERR : SRESP_DVA) : SRESP_NULL;
  assign sio_d_o    = 1'b0;  // open drain: only ever pulls low

  assign rx   = rd2 && (phase == PH_DATA);
  assign last = (phase == PH_DATA) || (cmd.rd && !rd2 && (phase == PH_ADDR));

  always_comb begin
    tx_byte = cmd.wdata;
    if (phase == PH_ID)        tx_byte = {cmd.id, rd2};
    else if (phase == PH_ADDR) tx_byte = cmd.reg_addr;
  end

  always_comb begin
    state_n = state; q_n = q; bitcnt_n = bitcnt; phase_n = phase; rd2_n = rd2;
    c_n = sio_c; oe_n = sio_d_oe; shreg_n = shreg; err_n = err;
    unique case (state)
      ST_IDLE: if (scmdaccept) begin
        q_n = 2'd0; bitcnt_n = 3'd7; phase_n = PH_ID; rd2_n = 1'b0;
        err_n   = (mcmd != MCMD_WR) && (mcmd != MCMD_RD);
        state_n = err_n ? ST_RESP : ST_START;
      end
      ST_START: if (tick) begin
        oe_n = 1'b1; state_n = ST_BYTE;
      end
      ST_BYTE, ST_XBIT: if (tick) begin
        q_n = q + 2'd1;
        case (q)
          2'd0: begin
            c_n  = 1'b0;
            oe_n = (state == ST_BYTE) && !rx && !tx_byte[bitcnt];
          end
          2'd2: begin
            c_n = 1'b1;
            if (state == ST_BYTE && rx) shreg_n = {shreg[6:0], sio_d_i};
          end
          2'd3: if (state == ST_BYTE) begin
            bitcnt_n = bitcnt - 3'd1;
            if (bitcnt == 3'd0) state_n = ST_XBIT;
          end else if (last) begin
            state_n = ST_STOP;
          end else begin
            state_n = ST_BYTE;
            phase_n = (rd2 && phase == PH_ID) ? PH_DATA : phase_t'(phase + 2'd1);
          end
          default: ;
        endcase
      end
      ST_STOP: if (tick) begin
        q_n = q + 2'd1;
        case (q)
          2'd0: begin c_n = 1'b0; oe_n = 1'b1; end
          2'd2: c_n = 1'b1;
          2'd3: begin
            oe_n = 1'b0;
            if (cmd.rd && !rd2) begin
              rd2_n = 1'b1; phase_n = PH_ID; state_n = ST_GAP;
            end else state_n = ST_RESP;
          end
          default: ;
        endcase
      end
      // Three idle quarters here plus START's lead-in quarter give four bus-free quarters.
      ST_GAP: if (tick) begin
        q_n = q + 2'd1;
        if (q == 2'd2) begin q_n = 2'd0; state_n = ST_START; end
      end
      ST_RESP: state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge config_clk or posedge config_reset)
    if (config_reset) begin
      state <= ST_IDLE; q <= '0; bitcnt <= '0; phase <= PH_ID; rd2 <= 1'b0;
      sio_c <= 1'b1; sio_d_oe <= 1'b0; shreg <= '0; err <= 1'b0; rdy <= 1'b0;
    end else begin
      state <= state_n; q <= q_n; bitcnt <= bitcnt_n; phase <= phase_n; rd2 <= rd2_n;
      sio_c <= c_n; sio_d_oe <= oe_n; shreg <= shreg_n; err <= err_n; rdy <= 1'b1;
    end

  always_ff @(posedge config_clk or posedge config_reset)
    if (config_reset) begin
      cmd   <= '0;
      sdata <= '0;
    end else begin
      if (scmdaccept)
        cmd <= {(mcmd == MCMD_RD), maddr[14:8], maddr[7:0], mdata, sccb_div};
      if (state == ST_STOP && tick && q == 2'd3 && rd2)
        sdata <= shreg;
    end
endmodule
